mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MEM_AW, default 16, memory address width.
REQ-002 Parameter MEM_DW, default 32, memory data width.
REQ-003 Parameter NREQ, default 4, requester count (2..4); IDW=2 bits of requester ID.
REQ-004 Parameter BURST, default 8, maximum transfers per ownership (1..255).
REQ-005 Parameter TAGD, default 8, outstanding-read tag FIFO depth (power of 2).
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 rq_req  in  NREQ  per-requester request, held until granted.
REQ-009 rq_write  in  NREQ  per-requester write flag (1=write, 0=read).
REQ-010 rq_addr  in  NREQ*MEM_AW  packed addresses; requester i at bits [i*MEM_AW +: MEM_AW].
REQ-011 rq_wdata  in  NREQ*MEM_DW  packed write data; same packing.
REQ-012 rq_gnt  out  NREQ  one-hot; transfer accepted for requester i this cycle.
REQ-013 rq_rdata_vld  out  NREQ  one-hot; read data returned to requester i.
REQ-014 rq_rdata  out  MEM_DW  read data shared by all requesters.
REQ-015 mem_req, mem_write  out  1  request and write flag to memory.
REQ-016 mem_addr  out  MEM_AW; mem_wdata  out  MEM_DW.
REQ-017 mem_gnt  in  1  memory accepts the presented request this cycle.
REQ-018 mem_rdata_vld  in  1; mem_rdata  in  MEM_DW  read return, in order of acceptance.
REQ-019 err_underflow  out  1  sticky: read data arrived with no outstanding tag.

Function
REQ-020 FSM states: IDLE (no owner), OWN (owner register valid).
REQ-021 IDLE: if any rq_req, select first asserted index at or after rr_ptr (wrapping), load owner, clear burst count, go OWN next cycle; no mem_req in IDLE.
REQ-022 OWN: mem_req = rq_req[owner] AND NOT (rq_write[owner]=0 AND tag FIFO full); mem_addr/mem_write/mem_wdata driven combinationally from owner's inputs.
REQ-023 Transfer = mem_req AND mem_gnt; rq_gnt[owner]=1 only on transfer; all other rq_gnt bits 0.
REQ-024 Each transfer increments the burst count (8-bit); a read transfer pushes owner ID into the tag FIFO.
REQ-025 OWN -> IDLE when rq_req[owner]=0, or a transfer occurs with burst count reaching BURST; rr_ptr <= owner+1 mod NREQ on exit.
REQ-026 Minimum latency request -> first grant: 1 cycle (IDLE cycle) plus memory stall.
REQ-027 On mem_rdata_vld: pop FIFO head; rq_rdata_vld[head]=1, rq_rdata=mem_rdata, same cycle (combinational).
REQ-028 Simultaneous push and pop: both occur, count unchanged; full check uses registered count (push blocked when count=TAGD even if pop same cycle).
REQ-029 mem_rdata_vld with FIFO empty: no rq_rdata_vld, no pop, set err_underflow until reset.
REQ-030 Writes never blocked by FIFO state; reads and writes from owner may interleave.
REQ-031 Owner dropping rq_req mid-burst releases ownership; outstanding reads still return to it.

Reset
REQ-032 On rst: state IDLE, rr_ptr=0, burst count=0, FIFO empty (count=0), err_underflow=0.
REQ-033 During and after reset, outputs rq_gnt=0, rq_rdata_vld=0, mem_req=0, mem_write=0; mem_addr/mem_wdata/rq_rdata don't-care when not valid.
REQ-034 Reset mid-burst discards outstanding tags; memory returns after reset flag err_underflow.

Verification
REQ-035 Single requester 1 reads addr 0x10, mem_gnt=1, data 0xAB 2 cycles later -> rq_gnt=0010 one cycle after IDLE, rq_rdata_vld=0010 with 0xAB.
REQ-036 All 4 requesters continuously requesting, BURST=8, mem_gnt=1 -> owners 0,1,2,3,0 each granted exactly 8 consecutive transfers, one idle cycle between owners.
REQ-037 Requester 0 issues 9 reads with no returns, TAGD=8 -> 8 grants, mem_req low thereafter; one mem_rdata_vld -> ninth read granted next cycle.
REQ-038 Interleaved reads from requesters 2 then 3, returns 0x11, 0x22 -> rq_rdata_vld 0100 with 0x11, then 1000 with 0x22.
REQ-039 mem_rdata_vld after reset with no reads issued -> err_underflow=1, held until rst.
REQ-040 mem_gnt held low 5 cycles during owner 1 write -> mem_addr/mem_wdata stable, rq_gnt=0 until mem_gnt=1, then single grant.

Source files
------------

// File: rtl/mem_arb_if.sv
// Requester-side and memory-side signals of the memory arbiter.
// master: the arbiter; slave: requesters plus memory.
interface mem_arb_if #(
  parameter int unsigned MEM_AW = 16,
  parameter int unsigned MEM_DW = 32,
  parameter int unsigned NREQ   = 4
);
  logic [NREQ-1:0]        rq_req;
  logic [NREQ-1:0]        rq_write;
  logic [NREQ*MEM_AW-1:0] rq_addr;
  logic [NREQ*MEM_DW-1:0] rq_wdata;
  logic [NREQ-1:0]        rq_gnt;
  logic [NREQ-1:0]        rq_rdata_vld;
  logic [MEM_DW-1:0]      rq_rdata;
  logic                   mem_req;
  logic                   mem_write;
  logic [MEM_AW-1:0]      mem_addr;
  logic [MEM_DW-1:0]      mem_wdata;
  logic                   mem_gnt;
  logic                   mem_rdata_vld;
  logic [MEM_DW-1:0]      mem_rdata;
  logic                   err_underflow;

  modport master (
    input  rq_req, rq_write, rq_addr, rq_wdata, mem_gnt, mem_rdata_vld, mem_rdata,
    output rq_gnt, rq_rdata_vld, rq_rdata, mem_req, mem_write, mem_addr, mem_wdata,
    output err_underflow
  );

  modport slave (
    output rq_req, rq_write, rq_addr, rq_wdata, mem_gnt, mem_rdata_vld, mem_rdata,
    input  rq_gnt, rq_rdata_vld, rq_rdata, mem_req, mem_write, mem_addr, mem_wdata,
    input  err_underflow
  );
endinterface

// File: rtl/mem_arb.sv
// Round-robin burst arbiter of NREQ requesters onto one memory port, with an
// in-order tag FIFO that routes read returns back to the issuing requester.
module mem_arb #(
  parameter int unsigned MEM_AW = 16,
  parameter int unsigned MEM_DW = 32,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned BURST  = 8,
  parameter int unsigned TAGD   = 8
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.master bus
);
  localparam int unsigned IDW = 2;
  localparam int unsigned PW  = (TAGD > 1) ? $clog2(TAGD) : 1;
  localparam int unsigned CW  = $clog2(TAGD + 1);
  localparam logic [IDW:0]  NreqW  = (IDW + 1)'(NREQ);
  localparam logic [7:0]    BurstW = 8'(BURST);
  localparam logic [PW-1:0] LastW  = PW'(TAGD - 1);
  localparam logic [CW-1:0] FullW  = CW'(TAGD);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]     burst_q, burst_d;
  logic [IDW-1:0] tag_q [TAGD];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic           err_q;

  logic [MEM_AW-1:0] addr_arr  [NREQ];
  logic [MEM_DW-1:0] wdata_arr [NREQ];

  logic           full, empty, own_req, xfer, push, pop;
  logic           idle_hit;
  logic [IDW-1:0] idle_pick, owner_inc;
  logic [IDW:0]   idx_sum, inc_sum;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.rq_addr[g*MEM_AW +: MEM_AW];
    assign wdata_arr[g] = bus.rq_wdata[g*MEM_DW +: MEM_DW];
  end

  assign full    = (cnt_q == FullW);
  assign empty   = (cnt_q == '0);
  // A read may not issue while every tag slot is taken; writes carry no tag.
  assign own_req = (state_q == StOwn) && bus.rq_req[owner_q] &&
                   !(!bus.rq_write[owner_q] && full);
  assign xfer    = own_req && bus.mem_gnt;
  assign push    = xfer && !bus.rq_write[owner_q];
  assign pop     = bus.mem_rdata_vld && !empty;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    idle_hit  = 1'b0;
    idle_pick = '0;
    idx_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (IDW + 1)'(k);
      if (idx_sum >= NreqW) idx_sum = idx_sum - NreqW;
      if (!idle_hit && bus.rq_req[idx_sum[IDW-1:0]]) begin
        idle_hit  = 1'b1;
        idle_pick = idx_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    inc_sum   = {1'b0, owner_q} + (IDW + 1)'(1);
    owner_inc = (inc_sum >= NreqW) ? '0 : inc_sum[IDW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    unique case (state_q)
      StIdle: begin
        if (idle_hit) begin
          owner_d = idle_pick;
          burst_d = '0;
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (xfer) burst_d = burst_q + 8'd1;
        if (!bus.rq_req[owner_q] || (xfer && (burst_q + 8'd1 == BurstW))) begin
          state_d  = StIdle;
          rr_ptr_d = owner_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_req       = own_req;
    bus.mem_write     = (state_q == StOwn) && bus.rq_write[owner_q];
    bus.mem_addr      = addr_arr[owner_q];
    bus.mem_wdata     = wdata_arr[owner_q];
    bus.rq_gnt        = xfer ? (NREQ'(1) << owner_q) : '0;
    bus.rq_rdata_vld  = pop ? (NREQ'(1) << tag_q[rd_ptr_q]) : '0;
    bus.rq_rdata      = bus.mem_rdata;
    bus.err_underflow = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      if (push) wr_ptr_q <= (wr_ptr_q == LastW) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastW) ? '0 : rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      if (bus.mem_rdata_vld && empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= owner_q;
  end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: expected grants and read returns are queued by
// the stimulus and consumed by a monitor as the DUT presents them.
module tb_mem_arb;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [3:0]    vec;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  logic [3:0] exp_gnt_q [$];
  rd_t        exp_rd_q  [$];
  logic [3:0] mon_gnt;
  rd_t        mon_rd;

  mem_arb_if #(.MEM_AW(AW), .MEM_DW(DW), .NREQ(4)) bus ();

  mem_arb #(
    .MEM_AW(AW), .MEM_DW(DW), .NREQ(4), .BURST(8), .TAGD(8)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, wanted %h", nm, act, exp);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rq_gnt != '0) begin
        checks++;
        if (exp_gnt_q.size() == 0) begin
          $display("FAIL gnt_unexpected: got %b, wanted no grant", bus.rq_gnt);
        end else begin
          mon_gnt = exp_gnt_q.pop_front();
          if (bus.rq_gnt === mon_gnt) passes++;
          else $display("FAIL gnt_order: got %b, wanted %b", bus.rq_gnt, mon_gnt);
        end
      end
      if (bus.rq_rdata_vld != '0) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          $display("FAIL rdata_unexpected: got %b/%h, wanted none", bus.rq_rdata_vld,
                   bus.rq_rdata);
        end else begin
          mon_rd = exp_rd_q.pop_front();
          if (bus.rq_rdata_vld === mon_rd.vec && bus.rq_rdata === mon_rd.data) passes++;
          else $display("FAIL rdata: got %b/%h, wanted %b/%h", bus.rq_rdata_vld,
                        bus.rq_rdata, mon_rd.vec, mon_rd.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rq_req        = '0;
    bus.rq_write      = '0;
    bus.rq_addr       = '0;
    bus.rq_wdata      = '0;
    bus.mem_gnt       = 1'b0;
    bus.mem_rdata_vld = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.rq_write[id]           = wr;
    bus.rq_addr[id*AW +: AW]   = a;
    bus.rq_wdata[id*DW +: DW]  = d;
    bus.rq_req[id]             = 1'b1;
  endtask

  // Wait (bounded) for a grant to requester id, then drop its request.
  task automatic wait_gnt(input int id, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rq_gnt[id]) seen = 1'b1;
    end
    if (!seen) chk(nm, 32'(seen), 32'd1);
    tick();
    bus.rq_req[id] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    int last;
    clear_inputs();
    @(negedge clk);
    chk("rst_gnt", 32'(bus.rq_gnt), 0);
    chk("rst_rvld", 32'(bus.rq_rdata_vld), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_write", 32'(bus.mem_write), 0);
    do_reset();
    chk("rst_err", 32'(bus.err_underflow), 0);

    // Single read from requester 1.
    exp_gnt_q.push_back(4'b0010);
    exp_rd_q.push_back('{vec: 4'b0010, data: 32'hAB});
    set_req(1, 1'b0, 16'h0010, '0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    chk("t1_idle_no_req", 32'(bus.mem_req), 0);
    @(negedge clk);
    chk("t1_gnt_latency", 32'(bus.rq_gnt), 32'b0010);
    chk("t1_addr", 32'(bus.mem_addr), 32'h10);
    chk("t1_write", 32'(bus.mem_write), 0);
    tick();
    bus.rq_req[1] = 1'b0;
    tick();
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata     = 32'hAB;
    tick();
    bus.mem_rdata_vld = 1'b0;

    // Four continuous writers: 8-transfer bursts, one idle cycle between owners.
    do_reset();
    for (int o = 0; o < 5; o++)
      for (int b = 0; b < 8; b++) exp_gnt_q.push_back(4'(1 << (o % 4)));
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'(16'h100 + i), 32'(i));
    bus.mem_gnt = 1'b1;
    ngr  = 0;
    last = 0;
    for (int c = 1; c <= 80 && ngr < 40; c++) begin
      @(negedge clk);
      if (bus.rq_gnt != '0) begin
        ngr++;
        last = c;
      end
    end
    tick();
    bus.rq_req = '0;
    chk("t2_grants", 32'(ngr), 40);
    chk("t2_cycles", 32'(last), 45);
    repeat (3) tick();

    // Tag FIFO full blocks the ninth read until one return frees a slot.
    do_reset();
    for (int i = 0; i < 9; i++) exp_gnt_q.push_back(4'b0001);
    exp_rd_q.push_back('{vec: 4'b0001, data: 32'h55});
    set_req(0, 1'b0, 16'h0040, '0);
    bus.mem_gnt = 1'b1;
    ngr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rq_gnt != '0) ngr++;
    end
    chk("t3_grants_full", 32'(ngr), 8);
    chk("t3_mem_req_full", 32'(bus.mem_req), 0);
    tick();
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata     = 32'h55;
    @(negedge clk);
    chk("t3_blocked_on_pop", 32'(bus.mem_req), 0);
    tick();
    bus.mem_rdata_vld = 1'b0;
    @(negedge clk);
    chk("t3_ninth_gnt", 32'(bus.rq_gnt), 32'b0001);
    tick();
    bus.rq_req[0] = 1'b0;

    // Reset discards outstanding tags; a late return is an underflow.
    do_reset();
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata     = 32'h77;
    @(negedge clk);
    chk("t5_no_rvld", 32'(bus.rq_rdata_vld), 0);
    tick();
    bus.mem_rdata_vld = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(bus.err_underflow), 1);
    repeat (3) tick();
    chk("t5_err_sticky", 32'(bus.err_underflow), 1);
    do_reset();
    chk("t5_err_cleared", 32'(bus.err_underflow), 0);

    // Reads from 2 then 3, returns routed in acceptance order.
    exp_gnt_q.push_back(4'b0100);
    exp_gnt_q.push_back(4'b1000);
    exp_rd_q.push_back('{vec: 4'b0100, data: 32'h11});
    exp_rd_q.push_back('{vec: 4'b1000, data: 32'h22});
    set_req(2, 1'b0, 16'h0200, '0);
    set_req(3, 1'b0, 16'h0300, '0);
    bus.mem_gnt = 1'b1;
    wait_gnt(2, "t4_gnt2_timeout");
    wait_gnt(3, "t4_gnt3_timeout");
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata     = 32'h11;
    tick();
    bus.mem_rdata     = 32'h22;
    tick();
    bus.mem_rdata_vld = 1'b0;
    tick();

    // Memory stall during a write from requester 1.
    do_reset();
    set_req(1, 1'b1, 16'h1234, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_stall_gnt", 32'(bus.rq_gnt), 0);
      chk("t6_stall_req", 32'(bus.mem_req), 1);
      chk("t6_stall_addr", 32'(bus.mem_addr), 32'h1234);
      chk("t6_stall_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      tick();
    end
    exp_gnt_q.push_back(4'b0010);
    bus.mem_gnt = 1'b1;
    wait_gnt(1, "t6_gnt_timeout");
    repeat (3) tick();

    chk("gnt_queue_drained", 32'(exp_gnt_q.size()), 0);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
